// File: rtl/coeff_sched_pkg.sv
// coeff_sched_pkg: shared constants, tag-width helper and operand/product types
// for the coeff_mult_scheduler family.
package coeff_sched_pkg;
    localparam int COEFF_DEFAULT = 30;
    localparam int DATA_W = 10;
    typedef logic signed [DATA_W-1:0] operand_t;
    typedef logic signed [2*DATA_W-1:0] product_t;
    function automatic int tag_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot arbiter; the search starts one past the last grant.
module rr_arbiter
    import coeff_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       en,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       gnt_vld,
    output logic [tag_w(NUM_REQ)-1:0]  gnt_idx
);
    localparam int TW = tag_w(NUM_REQ);
    logic [TW-1:0] last_q, last_d, idx;
    always_comb begin
        gnt = '0;
        gnt_vld = 1'b0;
        gnt_idx = last_q;
        idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = TW'((int'(last_q) + k) % NUM_REQ);
            if (en && !gnt_vld && req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
                gnt[idx] = 1'b1;
            end
        end
    end
    assign last_d = gnt_vld ? gnt_idx : last_q;
    always_ff @(posedge clk) begin
        last_q <= rst ? TW'(NUM_REQ - 1) : last_d;
    end
endmodule

// File: rtl/coeff_mult_scheduler.sv
// coeff_mult_scheduler: round-robin sharing of one pipelined signed multiplier among NUM_REQ lanes.
// Define COEFF_CFG_EN for writable per-lane coefficients; otherwise every lane uses COEFF_DEFAULT.
module coeff_mult_scheduler
    import coeff_sched_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int dataWidth_i   = 10,
    parameter int dataWidth_o   = 2*dataWidth_i,
    parameter int COEFF_DEFAULT = coeff_sched_pkg::COEFF_DEFAULT
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 in_valid,
    input  logic [NUM_REQ*dataWidth_i-1:0]     in_data,
    output logic [NUM_REQ-1:0]                 in_ready,
    input  logic                               cfg_we,
    input  logic [tag_w(NUM_REQ)-1:0]          cfg_idx,
    input  logic signed [dataWidth_i-1:0]      cfg_coeff,
    output logic                               out_valid,
    output logic signed [dataWidth_o-1:0]      out_data,
    output logic [tag_w(NUM_REQ)-1:0]          out_tag,
    input  logic                               out_ready
);
    localparam int TW = tag_w(NUM_REQ);
    localparam int PW = 2*dataWidth_i;
    localparam logic signed [dataWidth_i-1:0] C0 = dataWidth_i'(COEFF_DEFAULT);

    logic                          adv, gnt_vld;
    logic [TW-1:0]                 gnt_idx, s1_tag_q, out_tag_q;
    logic                          s1_v_q, out_valid_q;
    logic signed [dataWidth_i-1:0] s1_a_q, s1_c;
    logic signed [PW-1:0]          prod;
    logic signed [dataWidth_o-1:0] out_data_q;

    assign adv = !out_valid_q || out_ready;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (in_valid),
        .en      (adv && !rst),
        .gnt     (in_ready),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

`ifdef COEFF_CFG_EN
    logic signed [dataWidth_i-1:0] coeff_q [NUM_REQ];
    logic signed [dataWidth_i-1:0] s1_c_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            coeff_q <= '{default: C0};
            s1_c_q  <= '0;
        end else begin
            if (cfg_we && int'(cfg_idx) < NUM_REQ) coeff_q[cfg_idx] <= cfg_coeff;
            // The grant reads the pre-edge bank, so a same-cycle write is seen one grant later.
            if (adv) s1_c_q <= coeff_q[gnt_idx];
        end
    end
    assign s1_c = s1_c_q;
`else
    logic cfg_unused;
    assign cfg_unused = ^{cfg_we, cfg_idx, cfg_coeff};
    assign s1_c = C0;
`endif

    assign prod = PW'(s1_a_q) * PW'(s1_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q      <= 1'b0;
            s1_a_q      <= '0;
            s1_tag_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
        end else if (adv) begin
            s1_v_q      <= gnt_vld;
            s1_a_q      <= in_data[int'(gnt_idx)*dataWidth_i +: dataWidth_i];
            s1_tag_q    <= gnt_idx;
            out_valid_q <= s1_v_q;
            out_data_q  <= dataWidth_o'(prod);
            out_tag_q   <= s1_tag_q;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
endmodule

// File: doc/coeff_mult_scheduler.md
# coeff_mult_scheduler

Shares one pipelined signed constant-coefficient multiplier among `NUM_REQ` requesters (activation-function lanes) using round-robin arbitration with per-requester valid/ready handshakes. Each requester has its own coefficient register. Results come back tagged with the requester index. The block sits between the activation lanes and the shared DSP multiply resource, replacing one multiplier per lane.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, at least 2.
- `dataWidth_i`, 10: signed operand and coefficient width.
- `dataWidth_o`, `2*dataWidth_i`: signed product width.
- `COEFF_DEFAULT`, 30: signed reset and fixed coefficient value.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  `NUM_REQ`  per-requester request valid.
- `in_data`  in  `NUM_REQ*dataWidth_i`  signed operands; requester i occupies slice i.
- `in_ready`  out  `NUM_REQ`  one-hot grant (combinational); at most one bit high.
- `cfg_we`  in  1  coefficient write strobe.
- `cfg_idx`  in  `$clog2(NUM_REQ)`  coefficient register index.
- `cfg_coeff`  in  `dataWidth_i`  signed coefficient value.
- `out_valid`  out  1  result valid.
- `out_data`  out  `dataWidth_o`  signed product.
- `out_tag`  out  `$clog2(NUM_REQ)`  requester index of the result.
- `out_ready`  in  1  downstream accepts the result.

## Operation
- Pipeline advance: `adv = !out_valid || out_ready`. The whole pipeline moves only when `adv` is high. Bubbles are not collapsed.
- Arbitration: round-robin pointer `last`. The search starts at `last+1` and wraps modulo `NUM_REQ`. The first valid requester i is granted: `in_ready[i]=1`, but only when `adv` is high and `rst` is low. On a grant, `last <= i`. With no grant, `last` holds.
- Transfer: `in_valid[i] && in_ready[i]`. `in_ready` never depends on `in_valid` of any requester other than those ahead of it in the search order.
- Stage 1 (s1) captures `in_data[i]`, `coeff[i]`, the tag i and the valid bit. If there was no grant while `adv` was high, s1 valid becomes 0.
- Stage 2 (output) on `adv`: `out_data <= s1_a * s1_c`, computed at full signed `2*dataWidth_i` precision. If `dataWidth_o` is smaller, the LSBs are kept (two's-complement wrap). If larger, the result is sign-extended. `out_tag` and `out_valid` follow s1.
- Output hold: while `out_valid && !out_ready`, `out_data`, `out_tag` and `out_valid` hold, s1 holds, and no grants are issued.
- Coefficient write: `cfg_we` writes `coeff[cfg_idx]` at the edge. If a grant to the same index happens in the same cycle, it samples the old coefficient. An out-of-range `cfg_idx` is ignored.
- Reset:
  - `out_valid=0`, `out_data=0`, `out_tag=0`.
  - s1 cleared.
  - `last=NUM_REQ-1`, so requester 0 has first priority.
  - All `coeff=COEFF_DEFAULT`.
  - `in_ready=0` while `rst` is high.
- Reset mid-operation drops in-flight products with no output pulse.

## Timing
- Latency: a transfer at edge T gives `out_valid` high after edge T+1, for the cycle T+1 to T+2, when no stall occurs.
- Throughput: one result per cycle when `out_ready` is held high.
- Fairness: with all `NUM_REQ` requesters continuously valid, each is granted exactly once per `NUM_REQ` consecutive grants.
- Coefficient effect: a coefficient written at edge T applies to grants at edge T+1 and later.

## Configuration
- `COEFF_CFG_EN` defined: the coefficient register bank and the `cfg_*` ports behave as described.
- `COEFF_CFG_EN` undefined:
  - The `cfg_*` ports remain but are ignored.
  - No coefficient registers exist.
  - Every requester uses the constant `COEFF_DEFAULT`, so the multiply becomes constant-coefficient and maps to shift-add logic.

## Structure
- Package `coeff_sched_pkg` holds:
  - `COEFF_DEFAULT`
  - a tag-width function (`$clog2` with a minimum of 1)
  - the signed operand and product typedefs.
- Sub-module `rr_arbiter`: parameterised by `NUM_REQ`. Inputs are `req` and `en`; outputs are one-hot `gnt` and the pointer update. It is reused by other lane schedulers.
- Top level holds the coefficient bank, s1, and the output register.

## Test plan
- Reset, then requester 0 sends 5 with `out_ready=1` → `out_valid` 2 cycles later, `out_data=150`, `out_tag=0`.
- All 4 requesters valid with data 1, 2, 3, 4 continuously → grant order 0, 1, 2, 3, 0…; outputs 30, 60, 90, 120 on consecutive cycles.
- Write `coeff[2]=-7`, then requester 2 sends -512 → `out_data=3584`, `tag=2`. Repeat with the write and the grant in the same cycle → `out_data=-15360` (old coefficient 30).
- Hold `out_ready=0` for 3 cycles while results are pending → `out_data` and `out_tag` stable, `in_ready=0`, no result lost or duplicated after release.
- Assert `rst` while 2 results are in flight → `out_valid=0` next cycle; first grant afterwards goes to requester 0.
- Build without `COEFF_CFG_EN`, `cfg_we=1`, `cfg_coeff=-1`, then requester 1 sends 3 → `out_data=90`.
